// File: rtl/alarm_pattern_gen.sv
`default_nettype none
// alarm_pattern_gen: piezo tone driver with continuous, repeating-beep and counted-burst modes.
// Revision 1.0
module alarm_pattern_gen #(
  parameter int TONE_HALF = 25000,
  parameter int BEEP_ON   = 25000000,
  parameter int BEEP_OFF  = 25000000,
  parameter int CNT_W     = 26,
  parameter int COUNT_W   = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic               start,
  input  logic [COUNT_W-1:0] beep_count,
  output logic               BUZZER,
  output logic               active,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  localparam logic [1:0]         MODE_REPEAT = 2'd1;
  localparam logic [1:0]         MODE_BURST  = 2'd2;
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]   TONE_LAST   = CNT_W'(TONE_HALF - 1);
  localparam logic [CNT_W-1:0]   ON_LAST     = CNT_W'(BEEP_ON - 1);
  localparam logic [CNT_W-1:0]   OFF_LAST    = CNT_W'(BEEP_OFF - 1);
  localparam logic [COUNT_W-1:0] REM_ONE     = COUNT_W'(1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   tone_cnt, tone_nxt;
  logic [CNT_W-1:0]   phase_cnt, phase_nxt;
  logic [COUNT_W-1:0] remaining, remaining_nxt;
  logic [1:0]         mode_q, mode_nxt;
  logic               buzzer_nxt, done_nxt;

  logic gated;
  logic tone_wrap, on_last, off_last, last_beep;

  // Modes 0 and 3 sound continuously; only 1 and 2 run the on/off phase counter.
  assign gated     = (mode_q == MODE_REPEAT) || (mode_q == MODE_BURST);
  assign tone_wrap = (tone_cnt == TONE_LAST);
  assign on_last   = (phase_cnt == ON_LAST);
  assign off_last  = (phase_cnt == OFF_LAST);
  assign last_beep = (remaining == REM_ONE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      tone_cnt  <= '0;
      phase_cnt <= '0;
      remaining <= '0;
      mode_q    <= '0;
      BUZZER    <= 1'b0;
      active    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      tone_cnt  <= tone_nxt;
      phase_cnt <= phase_nxt;
      remaining <= remaining_nxt;
      mode_q    <= mode_nxt;
      BUZZER    <= buzzer_nxt;
      active    <= (state_nxt != IDLE);
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    tone_nxt      = tone_cnt;
    phase_nxt     = phase_cnt;
    remaining_nxt = remaining;
    mode_nxt      = mode_q;
    buzzer_nxt    = BUZZER;
    done_nxt      = 1'b0;

    case (state)
      IDLE: begin
        tone_nxt   = '0;
        phase_nxt  = '0;
        buzzer_nxt = 1'b0;
        if (enable) begin
          if (mode != MODE_BURST) begin
            mode_nxt  = mode;
            state_nxt = ON;
          end else if (start) begin
            mode_nxt      = mode;
            remaining_nxt = beep_count;
            if (beep_count == '0) begin
              done_nxt = 1'b1;
            end else begin
              state_nxt = ON;
            end
          end
        end
      end

      ON: begin
        if (!enable) begin
          state_nxt     = IDLE;
          tone_nxt      = '0;
          phase_nxt     = '0;
          remaining_nxt = '0;
          buzzer_nxt    = 1'b0;
        end else begin
          if (tone_wrap) begin
            tone_nxt   = '0;
            buzzer_nxt = ~BUZZER;
          end else begin
            tone_nxt = tone_cnt + CNT_ONE;
          end

          if (gated) begin
            if (on_last) begin
              // Leaving ON: silence the pin and rewind the tone for the next entry.
              phase_nxt  = '0;
              tone_nxt   = '0;
              buzzer_nxt = 1'b0;
              state_nxt  = OFF;
              if (mode_q == MODE_BURST) begin
                remaining_nxt = remaining - REM_ONE;
                if (last_beep) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
                end
              end
            end else begin
              phase_nxt = phase_cnt + CNT_ONE;
            end
          end
        end
      end

      OFF: begin
        buzzer_nxt = 1'b0;
        tone_nxt   = '0;
        if (!enable) begin
          state_nxt     = IDLE;
          phase_nxt     = '0;
          remaining_nxt = '0;
        end else if (off_last) begin
          phase_nxt = '0;
          state_nxt = ON;
        end else begin
          phase_nxt = phase_cnt + CNT_ONE;
        end
      end

      default: begin
        state_nxt     = IDLE;
        tone_nxt      = '0;
        phase_nxt     = '0;
        remaining_nxt = '0;
        buzzer_nxt    = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
